// File: rtl/running_avg.sv
// running_avg: streaming moving-average engine over the last 2^LOG2_N
// samples. A circular buffer and a running sum give one average per accepted
// sample once the window is full; avg_pulse marks each delivered average.
module running_avg #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              avg_pulse,
  output logic              full
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_q [N];
  logic [LOG2_N-1:0]   wp_q, wp_d;
  logic [LOG2_N-1:0]   fill_cnt_q, fill_cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                avg_pulse_q, avg_pulse_d;

  logic                xfer_in;
  logic                xfer_out;
  logic                last_fill;
  logic                load_avg;
  logic [SUM_W-1:0]    new_sum;

  // Single output register with no skid buffer: accept input only when the
  // output slot is free or being drained this cycle.
  assign in_ready  = ~rst & ~flush & (~out_valid_q | out_ready);
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid_q & out_ready;
  assign last_fill = (fill_cnt_q == LOG2_N'(N - 1));
  assign load_avg  = xfer_in & ((state_q == RUN) | last_fill);

  // The evicted entry is already part of the sum (zero during fill), so this
  // never underflows and the width never overflows.
  assign new_sum = sum_q + SUM_W'(in_data) - SUM_W'(buf_q[wp_q]);

  // Next-state logic for the FSM, window bookkeeping and output register.
  always_comb begin
    // NOTE: every _d gets a default hold value first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wp_d        = wp_q;
    fill_cnt_d  = fill_cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    avg_pulse_d = xfer_out;  // still reported when a drain meets a flush

    if (flush) begin
      state_d     = FILL;
      wp_d        = '0;
      fill_cnt_d  = '0;
      sum_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      if (xfer_in) begin
        sum_d = new_sum;
        wp_d  = wp_q + LOG2_N'(1);
        if (state_q == FILL) begin
          if (last_fill) begin
            state_d    = RUN;
            fill_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + LOG2_N'(1);
          end
        end
      end
      // A new load wins over a drain, giving back-to-back averages.
      if (load_avg) begin
        out_valid_d = 1'b1;
        out_data_d  = new_sum[SUM_W-1:LOG2_N];
      end else if (xfer_out) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= FILL;
      wp_q        <= '0;
      fill_cnt_q  <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      avg_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fill_cnt_q  <= fill_cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      avg_pulse_q <= avg_pulse_d;
    end
  end

  // Sample window storage, cleared in one cycle on rst/flush.
  always_ff @(posedge clk) begin
    // NOTE: this buffer is deliberately reset: the running sum subtracts the
    // evicted entry, which must read as zero while the window is filling.
    if (rst || flush) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else if (xfer_in) begin
      buf_q[wp_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign avg_pulse = avg_pulse_q;
  assign full      = (state_q == RUN);

endmodule

// File: tb/tb_running_avg.sv
// tb_running_avg: directed, table-driven bench for running_avg (DATA_W=8,
// N=8). Each table row is one clock cycle of stimulus with the expected
// in_ready for that cycle and the expected registered outputs after the edge.
module tb_running_avg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       avg_pulse;
  logic       full;

  int checks   = 0;
  int failures = 0;

  running_avg #(.DATA_W(8), .LOG2_N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .avg_pulse (avg_pulse),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_full;
    logic       e_pulse;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic r, input logic f,
                     input logic e_rdy, input logic e_ov, input logic [7:0] e_od,
                     input logic e_full, input logic e_pulse);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.f = f;
    x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_od = e_od; x.e_full = e_full; x.e_pulse = e_pulse;
    vecs.push_back(x);
  endtask

  // Eight samples of 16 from an empty window; average 16 on the eighth.
  task automatic run_fill(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'd16; out_ready = 1'b1; flush = 1'b0;
      #1;
      check($sformatf("%s%0d in_ready", tag, i), in_ready, 1);
      @(posedge clk); #1;
      check($sformatf("%s%0d out_valid", tag, i), out_valid, (i == 7));
      check($sformatf("%s%0d full", tag, i), full, (i == 7));
      check($sformatf("%s%0d avg_pulse", tag, i), avg_pulse, 0);
      if (i == 7) check($sformatf("%s%0d out_data", tag, i), out_data, 16);
    end
  endtask

  int exp_pulses = 0;
  int seen_pulses = 0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Fill scenario, then drain.
    for (int i = 0; i < 7; i++) add(1, 8'd16, 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'd16, 1, 0, 1, 1, 8'd16, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0);
    // Flush with a sample offered: not accepted.
    add(1, 8'd99, 1, 1, 0, 0, 0, 0, 0);
    // Ramp 0..15: averages 3..11, one pulse per average.
    for (int i = 0; i < 7; i++) add(1, 8'(i), 1, 0, 1, 0, 0, 0, 0);
    for (int i = 7; i < 16; i++) add(1, 8'(i), 1, 0, 1, 1, 8'(i - 4), 1, (i > 7));
    add(0, 0, 1, 0, 1, 0, 0, 1, 1);
    // Saturation: 20 samples of 255.
    add(0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i < 7) add(1, 8'd255, 1, 0, 1, 0, 0, 0, 0);
      else       add(1, 8'd255, 1, 0, 1, 1, 8'd255, 1, (i > 7));
    end
    // Backpressure: sum 1785 -> 223, stall 5 cycles, then 191, 159.
    add(1, 8'd0, 1, 0, 1, 1, 8'd223, 1, 1);
    for (int i = 0; i < 5; i++) add(1, 8'd0, 0, 0, 0, 1, 8'd223, 1, 0);
    add(1, 8'd0, 1, 0, 1, 1, 8'd191, 1, 1);
    add(1, 8'd0, 1, 0, 1, 1, 8'd159, 1, 1);
    add(0, 0, 1, 0, 1, 0, 0, 1, 1);
    // Flush with output pending: 1028 -> 128 held, then dropped by flush.
    add(1, 8'd8, 0, 0, 1, 1, 8'd128, 1, 0);
    add(1, 8'd50, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++) add(1, 8'(10 * k), 1, 0, 1, 0, 0, 0, 0);
    add(1, 8'd80, 1, 0, 1, 1, 8'd45, 1, 0);
    // Flush in the same cycle as an output transfer: pulse still emitted.
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);

    // Reset state.
    @(negedge clk);
    #1;
    check("reset in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset avg_pulse", avg_pulse, 0);
    check("reset full", full, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven section.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].v; in_data = vecs[i].d; out_ready = vecs[i].r; flush = vecs[i].f;
      #1;
      check($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_rdy);
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) check($sformatf("v%0d out_data", i), out_data, vecs[i].e_od);
      check($sformatf("v%0d full", i), full, vecs[i].e_full);
      check($sformatf("v%0d avg_pulse", i), avg_pulse, vecs[i].e_pulse);
      exp_pulses += int'(vecs[i].e_pulse);
      seen_pulses += int'(avg_pulse);
    end
    check("pulse total", seen_pulses, exp_pulses);

    // Reset mid-RUN with an average being drained: rst wins, no pulse.
    run_fill("pre");
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd200; out_ready = 1'b1;
    #1;
    check("midrst in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    check("midrst avg_pulse", avg_pulse, 0);
    check("midrst full", full, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    run_fill("post");
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post drain avg_pulse", avg_pulse, 1);
    check("post drain out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/running_avg.md
# running_avg

Streaming moving-average engine that sits directly upstream of the running-average counter/display stage. It accepts unsigned samples over a valid/ready handshake, holds the last 2^LOG2_N samples in a circular buffer, and emits the truncated window mean with a one-cycle `avg_pulse` per delivered average. `avg_pulse` is the event the downstream counter tallies and shows on the 7-segment displays.

## Interface

- `DATA_W`, 8: sample and average width, unsigned.
- `LOG2_N`, 3: log2 of window length; N = 2^LOG2_N (legal 1..6).
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: synchronous clear of window state; priority below `rst`.
- `in_valid`  in  1: sample offered.
- `in_data`  in  DATA_W: sample value.
- `in_ready`  out  1: block can accept a sample this cycle.
- `out_valid`  out  1: average held on `out_data`.
- `out_data`  out  DATA_W: window mean, truncated.
- `out_ready`  in  1: downstream accepts the average.
- `avg_pulse`  out  1: one-cycle pulse, one per completed output transfer; drives the counter.
- `full`  out  1: window holds N samples (RUN state).

## Operation

- Storage: N-entry buffer of DATA_W bits, write pointer `wp` (LOG2_N bits, wraps N-1 -> 0), running sum of DATA_W+LOG2_N bits. The sum cannot overflow.
- Input transfer happens when `in_valid & in_ready`. On a transfer:
  - sum <= sum + in_data - buf[wp];
  - buf[wp] <= in_data;
  - wp <= wp + 1 (mod N).
- Buffer entries are zero after reset/flush, so the subtraction is exact during fill.
- States:
  - FILL: fewer than N samples accepted. `fill_cnt` counts 0..N-1. A transfer with `fill_cnt` = N-1 moves to RUN.
  - RUN: steady state. Stays in RUN until `rst` or `flush`.
- Output generation:
  - A transfer in RUN, or the Nth transfer that causes the FILL->RUN move, loads `out_data` <= new_sum >> LOG2_N (bits [DATA_W+LOG2_N-1:LOG2_N]) and sets `out_valid`.
  - The first N-1 transfers after reset/flush produce no output.
- `in_ready` = ~rst & ~flush & (~out_valid | out_ready). There is a single output register and no skid buffer. Backpressure stalls input with no loss.
- `out_valid` clears on `out_valid & out_ready` unless a new average loads in the same cycle. In that case it stays high with the new data.
- `out_data` is stable while `out_valid & ~out_ready`.
- `avg_pulse` is registered: high for exactly the cycle after each `out_valid & out_ready` transfer.
- `flush`:
  - Zeroes the buffer (may take N cycles via a clear sweep; `in_ready` stays low until done), plus sum, `wp`, `fill_cnt`.
  - Clears `out_valid`, which drops any pending average, and returns to FILL.
  - `avg_pulse` is still emitted if an output transfer completed in the flush cycle.
- `rst` produces the same end state as `flush`, with all outputs forced to reset values.
- Reset values: `in_ready`=0 during rst, `out_valid`=0, `out_data`=0, `avg_pulse`=0, `full`=0.

## Timing

- Latency: a sample accepted at edge k has its average visible on `out_data`/`out_valid` after edge k (cycle k+1).
- Throughput: one sample per cycle while `out_ready` stays high.
- `avg_pulse` follows an output transfer at edge k and is high in cycle k+1 only.
- `full` rises in the cycle after the Nth accepted sample, together with the first `out_valid`.
- Simultaneous events:
  - `flush` together with `in_valid`: sample not accepted.
  - `rst` together with anything: rst wins.
  - Output drain and new load in the same cycle: back-to-back averages with no bubble.
- `in_ready` is low for N cycles after `flush`/`rst` deassert if a clear sweep is used. This is fixed at N cycles.

## Test plan

- Fill: N=8, eight samples of 16 with `out_ready`=1 -> no `out_valid` for samples 1-7. After the 8th, `out_data`=16, `full`=1, one `avg_pulse`.
- Ramp: samples 0..15 continuous -> averages 3,4,5,...,11 (floor of window mean). Each cycle produces exactly one `avg_pulse`, 9 in total.
- Saturation: 20 samples of 255 (DATA_W=8) -> every average = 255, no wrap.
- Backpressure:
  - `out_ready` held low for 5 cycles mid-stream -> `in_ready` low and `out_data` frozen.
  - Release -> resumes with no lost or duplicated average; `avg_pulse` count equals the number of transfers.
- Flush with output pending -> `out_valid` drops, `full`=0. The next 7 samples produce no output; the 8th produces the mean of the post-flush samples only.
- Reset mid-RUN -> all outputs at reset values next cycle; behaviour afterwards is identical to the Fill scenario.
